// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // One extra bit so LATENCY-1 always fits, including LATENCY=1.
    function automatic int cnt_width(input int latency);
        return $clog2(latency) + 1;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) * 34'(WORD_BYTES);
        return {2'b00, addr} < limit;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-masked synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [WORD_BYTES-1:0] be_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // NOTE: storage has no reset; clearing a RAM would force it into flops
    // and the contents are defined by software writes anyway.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MIPS MEM stage: fixed-latency word access with stall/ack.
// Optional byte-strobe writes are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o,
    output logic        busy_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          txn_we;
    logic [31:0]   txn_addr;
    logic [31:0]   txn_wdata;
    logic [3:0]    txn_be;
    logic          txn_err;
    logic          commit;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    // With LATENCY=1 the commit edge is also the capture edge, so the live inputs are used.
    assign txn_we    = (state_q == IDLE) ? we_i    : we_q;
    assign txn_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign txn_wdata = (state_q == IDLE) ? wdata_i : wdata_q;
    assign txn_be    = (state_q == IDLE) ? be_i    : be_q;

    assign txn_err = (txn_addr[1:0] != 2'b00) || !addr_in_range(txn_addr, DEPTH);

    // A reset pulse must never land a write, even though the array itself is not reset.
    assign commit = rst_i && (state_d == RESP);
    assign mem_we = commit && txn_we && !txn_err;

`ifdef DMEM_BYTE_STROBE_EN
    assign mem_be = txn_be;
`else
    logic unused_be;
    assign mem_be    = '1;
    assign unused_be = ^txn_be;
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (txn_addr[AW+1:2]),
        .wdata_i (txn_wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = rst_i && req_i;
                if (req_i) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if ((state_q == IDLE) && req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // Read data persists across writes; err is only ever set for the RESP cycle.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = 1'b0;
        if (commit) begin
            err_d = txn_err;
            if (txn_err) begin
                rdata_d = '0;
            end else if (!txn_we) begin
                rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ack_o   = (state_q == RESP);
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule
